// File: rtl/descrambler_pkg.sv
// Shared constants and types for the x^7+x^4+1 PLCP scrambler/descrambler.
package descrambler_pkg;
  localparam int LFSR_LEN = 7;
  localparam int LFSR_TAP = 4;
  typedef logic [LFSR_LEN:1] lfsr_state_t;
  localparam lfsr_state_t SEED_DEFAULT = 7'h7F;
endpackage

// File: rtl/scrambler_lfsr_step.sv
// Combinational WIDTH-bit advance of the x^7+x^4+1 LFSR, bit 0 first.
// Masked bits shift the received bit into the state (seed acquisition) and output 0.
module scrambler_lfsr_step
  import descrambler_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  lfsr_state_t      state_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] acq_mask,
  output lfsr_state_t      state_out,
  output lfsr_state_t      acq_state,
  output logic [WIDTH-1:0] data_out
);
  lfsr_state_t st;
  logic        s;

  always_comb begin
    st        = state_in;
    s         = 1'b0;
    acq_state = state_in;
    data_out  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s = st[LFSR_LEN] ^ st[LFSR_TAP];
      if (acq_mask[i]) begin
        st        = {st[LFSR_LEN-1:1], data_in[i]};
        acq_state = st;
      end else begin
        data_out[i] = data_in[i] ^ s;
        st          = {st[LFSR_LEN-1:1], s};
      end
    end
    state_out = st;
  end
endmodule

// File: rtl/parallel_descrambler.sv
// 802.11a PLCP DATA descrambler, WIDTH bits per beat, one register stage, valid/ready.
// SEED_RECOVERY_EN: recover the frame seed from the first 7 bits of each frame.
module parallel_descrambler
  import descrambler_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter lfsr_state_t INIT_SEED = SEED_DEFAULT
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic             In_Start,
  input  logic             In_Last,
  input  lfsr_state_t      Seed,
  output logic [WIDTH-1:0] Out_Data,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Out_Start,
  output logic             Out_Last,
  output lfsr_state_t      Seed_Out,
  output logic             Seed_Err
);
  lfsr_state_t      st, chain_in, chain_out, acq_state;
  logic [WIDTH-1:0] acq_mask, desc;
  logic             accept;

  assign In_Ready = ~Out_Valid | Out_Ready;
  assign accept   = In_Valid & In_Ready;

`ifdef SEED_RECOVERY_EN
  // acq_cnt holds acquisition bits still to come; 0 means not acquiring
  logic [2:0] acq_cnt, acq_rem, acq_nxt;
  logic       acq_done;
  logic       seed_unused;

  assign seed_unused = ^Seed;
  assign chain_in    = st;

  always_comb begin
    acq_rem  = In_Start ? 3'(LFSR_LEN) : acq_cnt;
    acq_mask = '0;
    for (int i = 0; i < WIDTH; i++) acq_mask[i] = (i < int'(acq_rem));
    acq_done = (acq_rem != 3'd0) && (int'(acq_rem) <= WIDTH);
    acq_nxt  = (int'(acq_rem) > WIDTH) ? acq_rem - 3'(WIDTH) : 3'd0;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      acq_cnt  <= 3'd0;
      Seed_Out <= INIT_SEED;
      Seed_Err <= 1'b0;
    end else if (accept) begin
      acq_cnt <= acq_nxt;
      if (acq_done) begin
        Seed_Out <= acq_state;
        Seed_Err <= (acq_state == '0);
      end else if (In_Start) begin
        Seed_Err <= 1'b0;
      end
    end
  end
`else
  logic acq_unused;

  assign acq_unused = ^acq_state;
  assign acq_mask   = '0;
  assign chain_in   = In_Start ? Seed : st;
  assign Seed_Err   = 1'b0;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)                  Seed_Out <= INIT_SEED;
    else if (accept && In_Start)   Seed_Out <= Seed;
  end
`endif

  scrambler_lfsr_step #(.WIDTH(WIDTH)) u_step (
    .state_in  (chain_in),
    .data_in   (In_Data),
    .acq_mask  (acq_mask),
    .state_out (chain_out),
    .acq_state (acq_state),
    .data_out  (desc)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      st        <= INIT_SEED;
      Out_Valid <= 1'b0;
      Out_Data  <= '0;
      Out_Start <= 1'b0;
      Out_Last  <= 1'b0;
    end else if (accept) begin
      st        <= chain_out;
      Out_Valid <= 1'b1;
      Out_Data  <= desc;
      Out_Start <= In_Start;
      Out_Last  <= In_Last;
    end else if (Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end
endmodule
